accel_arbiter: RTL and testbench

ACCEL_ARBITER -- requirements
Module: accel_arbiter

---
 rtl/accel_pkg.sv | 18 +
 rtl/accel_arbiter_if.sv | 37 +++
 rtl/accel_arbiter_rr_pick.sv | 32 +++
 rtl/accel_arbiter.sv | 124 ++++++++++++
 tb/tb_accel_arbiter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/accel_pkg.sv
// Shared types and defaults for the accelerator arbiter.
// FSM state encoding plus default burst-length width and watchdog slack.
package accel_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int LEN_W_DEF = 10;
  localparam int TMO_DEF   = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SETTLE,
    S_RUN,
    S_RELEASE,
    S_ABORT
  } state_e;

endpackage

// File: rtl/accel_arbiter_if.sv
// Requester/accelerator signal bundle for accel_arbiter.
// slave = arbiter side, master = requesters plus accelerator side.
interface accel_arbiter_if
  import accel_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int LEN_W = LEN_W_DEF
) ();

  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*LEN_W-1:0] req_len_flat;
  logic [NREQ-1:0]       grant;
  logic [ID_W-1:0]       grant_id;
  logic                  accel_start;
  logic [LEN_W-1:0]      accel_burst_len;
  logic                  accel_done;
  logic                  accel_rst;
  logic                  cmd_done;
  logic                  cmd_err;

  modport slave (
    input  req, req_len_flat, accel_done,
    output grant, grant_id, accel_start,
    output accel_burst_len, accel_rst,
    output cmd_done, cmd_err
  );

  modport master (
    output req, req_len_flat, accel_done,
    input  grant, grant_id, accel_start,
    input  accel_burst_len, accel_rst,
    input  cmd_done, cmd_err
  );

endinterface

// File: rtl/accel_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester
// found searching upward from last_i+1 with wrap.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] last_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [ID_W-1:0] id_o,
  output logic            valid_o
);

  int idx;

  always_comb begin
    onehot_o = '0;
    id_o     = '0;
    valid_o  = 1'b0;
    idx      = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = int'(last_i) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!valid_o && req_i[idx]) begin
        valid_o       = 1'b1;
        onehot_o[idx] = 1'b1;
        id_o          = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/accel_arbiter.sv
// Round-robin owner arbitration for a shared burst accelerator,
// with stale-done masking, watchdog abort and zero-length bypass.
module accel_arbiter
  import accel_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int TMO   = TMO_DEF
) (
  input logic             clk,
  input logic             rst_n,
  accel_arbiter_if.slave  bus
);

  localparam int ID_W = $clog2(NREQ);
  localparam int WD_W = LEN_W + $clog2(TMO) + 1;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              err_q, err_d;
  logic              rst_hold_q;

  logic [NREQ-1:0]   pick_oh;
  logic [ID_W-1:0]   pick_id;
  logic              pick_vld;
  logic [LEN_W-1:0]  pick_len;
  logic [WD_W-1:0]   wd_inc;
  logic [WD_W-1:0]   wd_lim;

  rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .req_i    (bus.req),
    .last_i   (last_q),
    .onehot_o (pick_oh),
    .id_o     (pick_id),
    .valid_o  (pick_vld)
  );

  assign pick_len = bus.req_len_flat[LEN_W*int'(pick_id) +: LEN_W];
  assign wd_inc   = wd_q + WD_W'(1);
  assign wd_lim   = WD_W'(len_q) + WD_W'(TMO);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    last_d  = last_q;
    len_d   = len_q;
    err_d   = err_q;
    // Saturate rather than wrap so a stuck burst always aborts
    wd_d    = (wd_q == '1) ? wd_q : wd_inc;
    unique case (state_q)
      S_IDLE: begin
        wd_d  = '0;
        err_d = 1'b0;
        if (pick_vld) begin
          grant_d = pick_oh;
          id_d    = pick_id;
          len_d   = pick_len;
          if (pick_len == '0) begin
            err_d   = 1'b1;
            state_d = S_RELEASE;
          end else begin
            state_d = S_START;
          end
        end
      end
      S_START:  state_d = S_SETTLE;
      S_SETTLE: state_d = S_RUN;
      S_RUN: begin
        if (bus.accel_done) state_d = S_RELEASE;
        else if (wd_inc >= wd_lim) state_d = S_ABORT;
      end
      S_ABORT: begin
        err_d   = 1'b1;
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        grant_d = '0;
        last_d  = id_q;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      id_q       <= '0;
      last_q     <= ID_W'(NREQ - 1);
      len_q      <= '0;
      wd_q       <= '0;
      err_q      <= 1'b0;
      rst_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      id_q       <= id_d;
      last_q     <= last_d;
      len_q      <= len_d;
      wd_q       <= wd_d;
      err_q      <= err_d;
      rst_hold_q <= 1'b0;
    end
  end

  assign bus.grant           = grant_q;
  assign bus.grant_id        = id_q;
  assign bus.accel_burst_len = len_q;
  assign bus.accel_start     = (state_q == S_START);
  assign bus.accel_rst       = (state_q == S_ABORT) | rst_hold_q;
  assign bus.cmd_done        = (state_q == S_RELEASE);
  assign bus.cmd_err         = err_q;

endmodule

// File: tb/tb_accel_arbiter.sv
// Directed bench for accel_arbiter with a simple accelerator model
// whose done level rises one cycle after the last beat.
module tb_accel_arbiter;

  localparam int NREQ  = 4;
  localparam int LEN_W = 10;
  localparam int TMO   = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic mdl_en;
  logic mdl_done;
  logic force_done;
  int   mcnt;
  int   n_chk = 0;
  int   n_fail = 0;

  accel_arbiter_if #(.NREQ(NREQ), .LEN_W(LEN_W)) bus ();

  accel_arbiter #(
    .NREQ  (NREQ),
    .LEN_W (LEN_W),
    .TMO   (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.accel_done = mdl_done | force_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt     <= 0;
      mdl_done <= 1'b0;
    end else begin
      if (bus.cmd_done) mdl_done <= 1'b0;
      if (bus.accel_start && mdl_en)
        mcnt <= int'(bus.accel_burst_len) + 1;
      else if (mcnt == 1) begin
        mdl_done <= 1'b1;
        mcnt     <= 0;
      end else if (mcnt > 1)
        mcnt <= mcnt - 1;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_len(input int k, input int l);
    bus.req_len_flat[LEN_W*k +: LEN_W] = LEN_W'(l);
  endtask

  // Steps one cycle at a time until cmd_done, recording events
  task automatic wait_done(input int bound,
                           output int k, output int ks,
                           output int ns, output int kr,
                           output int nr, output logic [3:0] gs,
                           output logic [3:0] g1, output int ls,
                           output int ids, output logic err,
                           output logic [3:0] gd);
    bit found;
    found = 1'b0;
    k = 0; ks = 0; ns = 0; kr = 0; nr = 0;
    gs = '0; g1 = '0; ls = 0; ids = 0;
    err = 1'b0; gd = '0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      k++;
      if (k == 1) g1 = bus.grant;
      if (bus.accel_start) begin
        ns++;
        ks  = k;
        gs  = bus.grant;
        ls  = int'(bus.accel_burst_len);
        ids = int'(bus.grant_id);
      end
      if (bus.accel_rst) begin
        nr++;
        kr = k;
      end
      if (bus.cmd_done) begin
        found = 1'b1;
        err   = bus.cmd_err;
        gd    = bus.grant;
      end
    end
    check("cmd_done_seen", 32'(found), 32'd1);
  endtask

  int k, ks, ns, kr, nr, ls, ids;
  logic [3:0] gs, g1, gd;
  logic err;

  initial begin
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.req_len_flat = '0;
    force_done   = 1'b0;
    mdl_en       = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_id", 32'(bus.grant_id), 32'd0);
    check("rst_start", 32'(bus.accel_start), 32'd0);
    check("rst_len", 32'(bus.accel_burst_len), 32'd0);
    check("rst_done", 32'(bus.cmd_done), 32'd0);
    check("rst_err", 32'(bus.cmd_err), 32'd0);
    check("rst_accel_rst", 32'(bus.accel_rst), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("accel_rst_rel", 32'(bus.accel_rst), 32'd0);

    // Fairness: all requesting, length 2 each
    for (int r = 0; r < NREQ; r++) set_len(r, 2);
    bus.req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      wait_done(50, k, ks, ns, kr, nr, gs, g1, ls, ids, err, gd);
      check("rr_grant", 32'(gs), 32'(4'b0001 << (b % 4)));
      check("rr_ks", 32'(ks), (b == 0) ? 32'd1 : 32'd2);
      check("rr_lat", 32'(k - ks), 32'd5);
      check("rr_err", 32'(err), 32'd0);
      if (b > 0) check("rr_gap", 32'(g1), 32'd0);
    end
    bus.req = '0;
    @(negedge clk);
    check("idle_grant", 32'(bus.grant), 32'd0);

    // Single request, length 5
    set_len(0, 5);
    bus.req = 4'b0001;
    wait_done(50, k, ks, ns, kr, nr, gs, g1, ls, ids, err, gd);
    bus.req = '0;
    check("one_ks", 32'(ks), 32'd1);
    check("one_ns", 32'(ns), 32'd1);
    check("one_id", 32'(ids), 32'd0);
    check("one_len", 32'(ls), 32'd5);
    check("one_lat", 32'(k - ks), 32'd8);
    check("one_err", 32'(err), 32'd0);
    @(negedge clk);

    // Zero length bypasses the accelerator
    set_len(2, 0);
    bus.req = 4'b0100;
    wait_done(5, k, ks, ns, kr, nr, gs, g1, ls, ids, err, gd);
    bus.req = '0;
    check("zero_k", 32'(k), 32'd1);
    check("zero_ns", 32'(ns), 32'd0);
    check("zero_err", 32'(err), 32'd1);
    check("zero_grant", 32'(gd), 32'd4);
    @(negedge clk);
    check("zero_err_clr", 32'(bus.cmd_err), 32'd0);

    // Watchdog: accelerator never finishes
    mdl_en = 1'b0;
    set_len(1, 4);
    bus.req = 4'b0010;
    wait_done(200, k, ks, ns, kr, nr, gs, g1, ls, ids, err, gd);
    bus.req = '0;
    mdl_en  = 1'b1;
    check("wd_ks", 32'(ks), 32'd1);
    check("wd_nr", 32'(nr), 32'd1);
    check("wd_rst_at", 32'(kr - ks), 32'd68);
    check("wd_done_at", 32'(k - ks), 32'd69);
    check("wd_err", 32'(err), 32'd1);
    @(negedge clk);

    // Stale done level through IDLE, START and SETTLE
    set_len(0, 3);
    bus.req    = 4'b0001;
    force_done = 1'b1;
    @(negedge clk);
    check("stale_start", 32'(bus.accel_start), 32'd1);
    @(negedge clk);
    check("stale_settle", 32'(bus.cmd_done), 32'd0);
    @(negedge clk);
    check("stale_run", 32'(bus.cmd_done), 32'd0);
    force_done = 1'b0;
    wait_done(50, k, ks, ns, kr, nr, gs, g1, ls, ids, err, gd);
    bus.req = '0;
    check("stale_k", 32'(k), 32'd4);
    check("stale_err", 32'(err), 32'd0);

    // Reset mid-RUN abandons the burst
    set_len(1, 20);
    bus.req = 4'b0010;
    repeat (6) @(negedge clk);
    check("mid_grant", 32'(bus.grant), 32'd2);
    check("mid_len", 32'(bus.accel_burst_len), 32'd20);
    rst_n   = 1'b0;
    bus.req = 4'b0011;
    set_len(0, 2);
    @(negedge clk);
    check("mrst_done", 32'(bus.cmd_done), 32'd0);
    @(negedge clk);
    check("mrst_grant", 32'(bus.grant), 32'd0);
    check("mrst_len", 32'(bus.accel_burst_len), 32'd0);
    check("mrst_start", 32'(bus.accel_start), 32'd0);
    check("mrst_arst", 32'(bus.accel_rst), 32'd1);
    rst_n = 1'b1;
    wait_done(50, k, ks, ns, kr, nr, gs, g1, ls, ids, err, gd);
    bus.req = '0;
    check("post_grant", 32'(gs), 32'd1);
    check("post_ks", 32'(ks), 32'd1);
    check("post_lat", 32'(k - ks), 32'd5);
    check("post_nr", 32'(nr), 32'd0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
